// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg
//   Shared constants and types for the adder tree feeder and its operand bank.
//   DATA_W   : operand and result width (sums wrap modulo 2^DATA_W)
//   N_IN     : operands per operation, fixed to the tree width
//   TREE_LAT : register stages in the adder tree, operand-stable to sum-valid
//   feeder_state_t : LOAD (collecting bytes), WAIT (tree latency), RESP (result out)
package adder_tree_pkg;

  localparam int DATA_W   = 8;
  localparam int N_IN     = 8;
  localparam int TREE_LAT = 3;

  localparam int IDX_W    = $clog2(N_IN);
  localparam int CNT_W    = $clog2(TREE_LAT + 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/feeder_operand_bank.sv
// feeder_operand_bank
//   Holds the N_IN operand bytes presented in parallel to the adder tree and the
//   write index that steps through them as serial bytes arrive.
//   clk      : rising-edge clock
//   clr      : synchronous clear of all operands and of the write index
//   wr_en    : write wr_data into the slot at the current index and advance it
//   wr_data  : operand byte to store
//   op0..op7 : stored operands, driven straight onto tree inputs in0..in7
//   last     : the current index is the final slot of the frame
//   empty    : the current index is slot 0 (no partial frame collected)
module feeder_operand_bank
  import adder_tree_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] op0,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] op3,
  output logic [DATA_W-1:0] op4,
  output logic [DATA_W-1:0] op5,
  output logic [DATA_W-1:0] op6,
  output logic [DATA_W-1:0] op7,
  output logic              last,
  output logic              empty
);

  logic [DATA_W-1:0] ops_q [N_IN];
  logic [IDX_W-1:0]  idx_q;

  assign last  = (idx_q == IDX_W'(N_IN - 1));
  assign empty = (idx_q == '0);

  // Operands are only overwritten by a write to their own slot, so a completed
  // frame stays visible to the tree until the next frame replaces it. The
  // index wraps back to slot 0 after the final byte of a frame.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N_IN; i++) begin
        ops_q[i] <= '0;
      end
      idx_q <= '0;
    end else if (wr_en) begin
      ops_q[idx_q] <= wr_data;
      idx_q        <= last ? '0 : idx_q + IDX_W'(1);
    end
  end

  assign op0 = ops_q[0];
  assign op1 = ops_q[1];
  assign op2 = ops_q[2];
  assign op3 = ops_q[3];
  assign op4 = ops_q[4];
  assign op5 = ops_q[5];
  assign op6 = ops_q[6];
  assign op7 = ops_q[7];

endmodule

// File: rtl/adder_tree_feeder.sv
// adder_tree_feeder
//   Front/back-end controller for the pipelined 8-input adder tree. Collects
//   N_IN bytes from a serial valid/ready stream, presents them in parallel on
//   op0..op7, waits out the tree latency, captures tree_sum and returns it on a
//   valid/ready result stream. One operation is in flight at a time.
//   clk, rst        : clock and synchronous active-high reset (the tree must
//                     share this reset)
//   in_valid/in_data/in_ready    : serial operand stream
//   op0..op7        : parallel operands to tree in0..in7
//   tree_sum        : tree final sum register
//   res_valid/res_data/res_ready : result stream
//   busy            : high unless idle in LOAD with no partial frame
//   frame_cnt       : result handshake count, wraps at 16 bits; present only
//                     when FEEDER_FRAME_CNT_EN is defined
module adder_tree_feeder
  import adder_tree_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] op0,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] op3,
  output logic [DATA_W-1:0] op4,
  output logic [DATA_W-1:0] op5,
  output logic [DATA_W-1:0] op6,
  output logic [DATA_W-1:0] op7,
  input  logic [DATA_W-1:0] tree_sum,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ready,
  output logic              busy
`ifdef FEEDER_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  feeder_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              wr_en;
  logic              bank_last;
  logic              bank_empty;
  logic              res_fire;

  // Reset doubles as the bank clear, so a partial frame is dropped together
  // with the rest of the controller state.
  feeder_operand_bank u_bank (
    .clk     (clk),
    .clr     (rst),
    .wr_en   (wr_en),
    .wr_data (in_data),
    .op0     (op0),
    .op1     (op1),
    .op2     (op2),
    .op3     (op3),
    .op4     (op4),
    .op5     (op5),
    .op6     (op6),
    .op7     (op7),
    .last    (bank_last),
    .empty   (bank_empty)
  );

  assign in_ready  = (state_q == LOAD);
  assign res_valid = (state_q == RESP);
  assign res_data  = res_data_q;
  assign busy      = (state_q != LOAD) || !bank_empty;
  assign res_fire  = res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      cnt_q      <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
    end
  end

  // The counter is loaded with TREE_LAT on the edge that writes the final
  // operand, then counts down; capture happens on the edge after it reaches
  // zero, TREE_LAT+1 edges after the last operand was written. That gives the
  // tree's final register one full cycle of settled output before sampling.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    wr_en      = 1'b0;
    case (state_q)
      LOAD: begin
        wr_en = in_valid;
        if (in_valid && bank_last) begin
          cnt_d   = CNT_W'(TREE_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          res_data_d = tree_sum;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (res_fire) begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

`ifdef FEEDER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Free-running count of delivered results; natural 16-bit wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (res_fire) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_adder_tree_feeder.sv
// tb_adder_tree_feeder
//   Drives serial frames into adder_tree_feeder, models the 3-stage adder tree
//   on its parallel outputs, and compares results against a reference that sums
//   each frame's bytes modulo 256 and expects the result TREE_LAT+1 edges after
//   the final accepted byte.
module tb_adder_tree_feeder;
  import adder_tree_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] ops_w [N_IN];
  logic [DATA_W-1:0] tree_sum;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;
  logic              busy;
`ifdef FEEDER_FRAME_CNT_EN
  logic [15:0]       frame_cnt;
`endif

  int compared = 0;
  int failed   = 0;
  int frames_done = 0;

  logic [DATA_W-1:0] frame_b [N_IN];

  always #5 clk = ~clk;

  adder_tree_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .op0       (ops_w[0]),
    .op1       (ops_w[1]),
    .op2       (ops_w[2]),
    .op3       (ops_w[3]),
    .op4       (ops_w[4]),
    .op5       (ops_w[5]),
    .op6       (ops_w[6]),
    .op7       (ops_w[7]),
    .tree_sum  (tree_sum),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .busy      (busy)
`ifdef FEEDER_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  // Adder tree stand-in: three register stages, the first sampling the full sum
  // of the current operands, all cleared by the shared reset.
  logic [DATA_W-1:0] tree_in_sum;
  logic [DATA_W-1:0] t1, t2, t3;

  always_comb begin
    tree_in_sum = '0;
    for (int i = 0; i < N_IN; i++) tree_in_sum = tree_in_sum + ops_w[i];
  end

  always @(posedge clk) begin
    if (rst) begin
      t1 <= '0; t2 <= '0; t3 <= '0;
    end else begin
      t1 <= tree_in_sum; t2 <= t1; t3 <= t2;
    end
  end
  assign tree_sum = t3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOps(input string tag);
    for (int i = 0; i < N_IN; i++) checkOutput(tag, 32'(ops_w[i]), 32'(frame_b[i]));
  endtask

  function automatic logic [DATA_W-1:0] refSum();
    int s = 0;
    for (int i = 0; i < N_IN; i++) s += int'(frame_b[i]);
    return DATA_W'(s % 256);
  endfunction

  // Sends frame_b, optionally with an idle cycle before each byte after the
  // first, then waits for the result, holds res_ready low for 'hold' cycles
  // (optionally pulsing junk bytes that must be ignored) and completes the
  // handshake.
  task automatic applyStimulus(input bit gaps, input int hold, input bit junk);
    logic [DATA_W-1:0] exp_sum;
    int lat;
    exp_sum   = refSum();
    res_ready = (hold == 0);
    for (int i = 0; i < N_IN; i++) begin
      if (gaps && i > 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
        checkOutput("gap_in_ready", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b1;
      in_data  = frame_b[i];
      tick();
    end
    in_valid = 1'b0;
    checkOutput("wait_in_ready", 32'(in_ready), 32'd0);
    checkOutput("wait_busy", 32'(busy), 32'd1);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!res_valid && lat < 20);
    checkOutput("latency", 32'(lat), 32'(TREE_LAT + 1));
    checkOutput("res_data", 32'(res_data), 32'(exp_sum));
    checkOps("ops_loaded");
    for (int k = 0; k < hold; k++) begin
      if (junk) begin
        in_valid = 1'(k);
        in_data  = 8'($urandom);
      end
      tick();
      checkOutput("bp_res_valid", 32'(res_valid), 32'd1);
      checkOutput("bp_res_data", 32'(res_data), 32'(exp_sum));
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    end
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
    end
    res_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    res_ready = 1'b0;
    frames_done++;
    checkOutput("hs_res_valid", 32'(res_valid), 32'd0);
    checkOutput("hs_in_ready", 32'(in_ready), 32'd1);
    checkOutput("hs_busy", 32'(busy), 32'd0);
    checkOps("ops_held");
`ifdef FEEDER_FRAME_CNT_EN
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(frames_done));
`endif
  endtask

  task automatic checkResetValues();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_data", 32'(res_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < N_IN; i++) checkOutput("rst_op", 32'(ops_w[i]), 32'd0);
`ifdef FEEDER_FRAME_CNT_EN
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkResetValues();

    // Sum of 1..8
    for (int i = 0; i < N_IN; i++) frame_b[i] = 8'(i + 1);
    applyStimulus(1'b0, 0, 1'b0);

    // Modulo wrap with all 0xFF
    for (int i = 0; i < N_IN; i++) frame_b[i] = 8'hFF;
    applyStimulus(1'b0, 0, 1'b0);

    // Gaps on alternate cycles
    for (int i = 0; i < N_IN; i++) frame_b[i] = 8'h10;
    applyStimulus(1'b1, 0, 1'b0);

    // Backpressure with junk in_valid pulses
    for (int i = 0; i < N_IN; i++) frame_b[i] = 8'($urandom);
    applyStimulus(1'b0, 10, 1'b1);

    // Reset after a partial frame of five bytes
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(1, 255));
      tick();
    end
    in_valid = 1'b0;
    checkOutput("partial_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    frames_done = 0;
    checkResetValues();

    for (int i = 0; i < N_IN; i++) frame_b[i] = 8'h01;
    applyStimulus(1'b0, 0, 1'b0);

    // Randomized frames with random gaps and backpressure
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N_IN; i++) frame_b[i] = 8'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                    1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/adder_tree_feeder.md
Name: adder_tree_feeder

Overview:
- Front-end and back-end controller for the 3-stage pipelined 8-input adder tree.
- Collects 8 bytes serially over a valid/ready stream and drives them in parallel onto the tree's in0..in7.
- Counts out the tree latency, captures the tree's final sum and returns it on a valid/ready result stream.
- Only one operation is in flight at a time.

Parameters:
- DATA_W, 8: operand and result width.
- N_IN, 8: operands per operation. Fixed to the tree width.
- TREE_LAT, 3: register stages in the adder tree, from operand-stable to sum-valid.

Ports:
- clk  input  1  rising-edge clock. The single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  serial operand valid.
- in_data  input  DATA_W  serial operand byte.
- in_ready  output  1  feeder accepts an operand this cycle.
- op0..op7  output  DATA_W each  parallel operands to tree in0..in7.
- tree_sum  input  DATA_W  from tree final_sum_reg.
- res_valid  output  1  result available.
- res_data  output  DATA_W  captured sum.
- res_ready  input  1  result consumer accepts.
- busy  output  1  high in any state other than LOAD with idx=0.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset values: in_ready=1, op0..op7=0, res_valid=0, res_data=0, busy=0, state=LOAD, idx=0, wait counter=0.
- States: LOAD, WAIT, RESP.
- LOAD:
  - in_ready=1.
  - On each in_valid&&in_ready edge, in_data is written to op[idx] and idx increments.
  - The first accepted byte goes to op0.
  - Gaps in in_valid are allowed; idx holds during gaps.
  - On acceptance with idx==N_IN-1: idx returns to 0, the counter loads TREE_LAT, and state goes to WAIT. Call this edge E0.
- WAIT:
  - in_ready=0. op0..op7 are held stable.
  - The counter decrements once per cycle.
  - When the counter is 0, the next edge captures tree_sum into res_data, sets res_valid=1 and moves to RESP.
  - This capture edge is E0+TREE_LAT+1, i.e. E0+4 for the default.
- RESP:
  - res_valid=1, in_ready=0. res_data is held stable until the handshake.
  - On res_valid&&res_ready: res_valid=0 next cycle and state returns to LOAD.
  - A new byte cannot be accepted in the handshake cycle; in_ready rises the cycle after.
- Operand and result rules:
  - Operands stay held after the response until overwritten by the next frame.
  - The sum is modulo 2^DATA_W; it wraps with no carry out, matching the tree.
- Boundary conditions:
  - in_valid asserted during WAIT or RESP is ignored. The byte is not consumed, since in_ready=0.
  - res_ready asserted when res_valid=0 has no effect.
  - rst in any state, including mid-LOAD or WAIT, returns everything to the reset values on the next edge.
  - A partial frame is discarded on reset.
  - The tree must be reset by the same rst.

Optional Feature:
- Macro: FEEDER_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [15:0], reset to 0.
  - Increments on each result handshake (res_valid&&res_ready) and wraps 0xFFFF→0x0000.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Shared package adder_tree_pkg holds:
  - DATA_W, N_IN, TREE_LAT constants.
  - State enum feeder_state_t {LOAD, WAIT, RESP}.
- The operand register file with its write-index logic is a natural sub-module, feeder_operand_bank. It takes wr_en, wr_data and clr, and exposes op0..op7 and a last flag.
- The FSM, counter and result register stay in the top.

Test Plan:
- Sum: feed 1,2,...,8 back-to-back with res_ready=1 → res_valid rises 4 cycles after the 8th handshake edge; res_data=0x24.
- Wrap: feed eight 0xFF → res_data=0xF8.
- Gaps: feed 0x10×8 with in_valid low on alternate cycles → idx holds during gaps; res_data=0x80; latency is still 4 cycles from the 8th accept.
- Backpressure:
  - Hold res_ready=0 for 10 cycles after res_valid rises → res_data stays stable and in_ready=0 throughout.
  - Any in_valid pulses during that time are not consumed.
  - Releasing res_ready → one handshake, then in_ready=1 the next cycle.
- Reset mid-operation:
  - Assert rst after 5 bytes → all outputs take their reset values.
  - Then feed 8 fresh bytes 0x01 → res_data=0x08, with no carry-over from the partial frame.
- Frame counter, with FEEDER_FRAME_CNT_EN defined: run 3 frames → frame_cnt=3.
  - Preload-free wrap check: frame_cnt goes 0xFFFF→0 after 65536 handshakes, covered by a forced-state test.
